// File: rtl/stream_skid_pkg.sv
// Shared definitions for the stream skid buffer.
//   skid_state_e         : occupancy state of the two-entry buffer
//   StallCntWidthDefault : default width of the optional output stall counter
package stream_skid_pkg;

  typedef enum logic [1:0] {
    SkidEmpty = 2'd0,
    SkidOne   = 2'd1,
    SkidFull  = 2'd2
  } skid_state_e;

  localparam int StallCntWidthDefault = 16;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry stream register (skid buffer) that cuts every combinational path
// between its input and output ports: ready_o, valid_o and data_o come
// straight from flops. One transfer per cycle, 1-cycle latency, FIFO order.
//
// Optional feature: define STREAM_SKID_STALL_CNT_EN to add stall_cnt_o, a
// saturating count of cycles with valid_o & ~ready_i.
//
// Handshake (both ports): a beat transfers on a clk_i edge where valid and
// ready are both high; the sender holds valid/data stable until that edge.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   clr_i        synchronous clear, drops all stored entries
//   valid_i      input payload valid
//   ready_o      buffer can accept (registered)
//   data_i       input payload
//   valid_o      output payload valid (registered)
//   ready_i      downstream accepts
//   data_o       output payload (registered, slot A)
//   state_o      debug view of the occupancy state
//   stall_cnt_o  output stall cycles (STREAM_SKID_STALL_CNT_EN only)
module stream_skid_buffer
  import stream_skid_pkg::*;
#(
  parameter type T               = logic,
  parameter int  STALL_CNT_WIDTH = StallCntWidthDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  T            data_i,
  output logic        valid_o,
  input  logic        ready_i,
  output T            data_o,
  output skid_state_e state_o
`ifdef STREAM_SKID_STALL_CNT_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
`endif
);

  skid_state_e state_q, state_d;
  T            a_q, a_d;   // head slot, drives data_o
  T            b_q, b_d;   // skid slot, used only when FULL
  logic        ready_q, ready_d;
  logic        push, pop;

  assign valid_o = (state_q != SkidEmpty);
  assign ready_o = ready_q;
  assign data_o  = a_q;
  assign state_o = state_q;

  assign push = valid_i & ready_q;
  assign pop  = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    if (clr_i) begin
      // Clear wins over any same-cycle handshake; stored data just goes stale.
      state_d = SkidEmpty;
    end else begin
      unique case (state_q)
        SkidEmpty: begin
          if (push) begin
            a_d     = data_i;
            state_d = SkidOne;
          end
        end
        SkidOne: begin
          if (push && pop) begin
            a_d = data_i;
          end else if (push) begin
            b_d     = data_i;
            state_d = SkidFull;
          end else if (pop) begin
            state_d = SkidEmpty;
          end
        end
        SkidFull: begin
          // ready_q is low here, so no push can arrive.
          if (pop) begin
            a_d     = b_q;
            state_d = SkidOne;
          end
        end
        default: state_d = SkidEmpty;
      endcase
    end
    // Ready is a flop: decided from where the buffer will be next cycle.
    ready_d = (state_d != SkidFull);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SkidEmpty;
      a_q     <= '0;
      b_q     <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ready_q <= ready_d;
    end
  end

`ifdef STREAM_SKID_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (clr_i) begin
      stall_cnt_d = '0;
    end else if (valid_o && !ready_i && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  // Counter width is meaningless without the counter.
  logic unused_stall_cfg;
  assign unused_stall_cfg = ^STALL_CNT_WIDTH;
`endif

endmodule

// File: doc/stream_skid_buffer.md
Name: stream_skid_buffer

Overview:
- Two-entry stream register with a ready/valid handshake on both ports.
- Fully cuts combinational paths: ready_o, valid_o and data_o are all driven straight from flops.
- Sustains one transfer per cycle with 1-cycle latency.
- Sits at stream boundaries needing timing isolation; complement to the forwarding (non-cutting) register used for default-ready behaviour.

Parameters:
- T, logic: payload type; width taken as $bits(T).
- STALL_CNT_WIDTH, 16: stall counter width; only used when the optional feature is compiled in.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- clr_i  input  1  synchronous clear; drops all stored entries.
- valid_i  input  1  input payload valid.
- ready_o  output  1  buffer can accept; registered.
- data_i  input  $bits(T)  input payload.
- valid_o  output  1  output payload valid; registered.
- ready_i  input  1  downstream accepts.
- data_o  output  $bits(T)  output payload; registered.
- stall_cnt_o  output  STALL_CNT_WIDTH  output stall cycles (only with STREAM_SKID_STALL_CNT_EN).

Behaviour:
- Reset: the one clock is clk_i; reset rst_i is asynchronous and active-high.
  - While rst_i=1: state EMPTY, slots A and B data = '0, valid_o=0, ready_o=0.
  - ready_o rises in the first clk_i edge after rst_i deasserts.
  - Reset mid-operation discards both entries immediately (async).
- Storage:
  - Slot A drives data_o; slot B is the skid slot.
  - push = valid_i & ready_o; pop = valid_o & ready_i.
  - Outputs: valid_o = (state != EMPTY); ready_o = ready_q, where ready_q <= (next_state != FULL).
- States and transitions, evaluated at the clk_i edge:
  - EMPTY: push -> A<=data_i, ONE. Otherwise stay.
  - ONE, push & pop -> A<=data_i, stay ONE (full throughput).
  - ONE, push & ~pop -> B<=data_i, FULL.
  - ONE, ~push & pop -> EMPTY.
  - ONE, neither -> hold.
  - FULL: pop -> A<=B, ONE. ready_o=0, so push is impossible. No pop -> hold.
- Latency and ordering:
  - data_i accepted at edge N appears on data_o after edge N (1 cycle).
  - FIFO order is strictly preserved.
- Handshake rules:
  - valid_o and data_o stay stable while valid_o & ~ready_i.
  - valid_o never depends combinationally on valid_i; ready_o never depends combinationally on ready_i.
  - valid_i may drop without a handshake; no data is captured in that case.
- clr_i: highest priority.
  - Next state EMPTY and ready_q=1.
  - Any push or pop in the same cycle is ignored for state purposes.
  - Outputs in the clr cycle are the current registered values; data is lost by design.
- Simultaneous clr_i and rst_i: rst_i wins.
- Data flops load only on the transitions listed; otherwise they hold.

Optional Feature:
- Macro: STREAM_SKID_STALL_CNT_EN.
- Defined:
  - Adds port stall_cnt_o.
  - Counter increments each cycle valid_o & ~ready_i and saturates at all-ones.
  - Reset to 0 by rst_i; cleared to 0 by clr_i.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Package stream_skid_pkg:
  - skid_state_e {SkidEmpty, SkidOne, SkidFull}, 2-bit.
  - StallCntWidthDefault = 16.
- No sub-module; the saturating stall counter is inline under the macro.

Test Plan:
- Reset release, ready_i=1, valid_i=1, data 0x1..0x8 back-to-back -> ready_o=1 from cycle 1; data_o=0x1..0x8 one cycle later; 8 transfers in 8 cycles; no gaps.
- ready_i=0, push 0xA then 0xB -> after 2 edges state FULL, ready_o=0, data_o=0xA. Raise ready_i -> 0xA then 0xB emitted; ready_o=1 one cycle after the first pop.
- Random valid_i/ready_i (50%), 1000 items -> scoreboard order exact; valid_o/data_o stable under backpressure; no loss or duplication.
- State FULL (0x3, 0x4 held), clr_i=1 with ready_i=1 -> next cycle valid_o=0, ready_o=1. Subsequent push 0x5 emerges as data_o=0x5.
- rst_i asserted mid-stream while FULL -> valid_o=0, ready_o=0 immediately without a clock edge; data_o='0.
- With STREAM_SKID_STALL_CNT_EN, STALL_CNT_WIDTH=4, valid_o=1 and ready_i=0 for 20 cycles -> stall_cnt_o=15 (saturated). clr_i -> stall_cnt_o=0 next cycle.
